// File: rtl/cache_arbiter_if.sv
// Handshake bundle between two requesters (A fetch, B data), the arbiter
// and the cache. Modports: slave = arbiter view, master = environment view.
//
// Ports (signals):
//   a_req/a_rw/a_addr/a_wdata -> arbiter; a_ack/a_rdata <- arbiter
//   b_req/b_rw/b_addr/b_wdata -> arbiter; b_ack/b_rdata <- arbiter
//   c_enab/c_rw/c_addr/c_wdata <- arbiter; c_rdata/c_hit -> arbiter
//   busy/owner <- arbiter status
interface cache_arbiter_if #(
   parameter int d_width = 8,
   parameter int a_width = 8
);
   logic               a_req;
   logic               a_rw;
   logic [a_width-1:0] a_addr;
   logic [d_width-1:0] a_wdata;
   logic               a_ack;
   logic [d_width-1:0] a_rdata;

   logic               b_req;
   logic               b_rw;
   logic [a_width-1:0] b_addr;
   logic [d_width-1:0] b_wdata;
   logic               b_ack;
   logic [d_width-1:0] b_rdata;

   logic               c_enab;
   logic               c_rw;
   logic [a_width-1:0] c_addr;
   logic [d_width-1:0] c_wdata;
   logic [d_width-1:0] c_rdata;
   logic               c_hit;

   logic               busy;
   logic               owner;

   modport slave (
      input  a_req, a_rw, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_rw, b_addr, b_wdata,
      output b_ack, b_rdata,
      output c_enab, c_rw, c_addr, c_wdata,
      input  c_rdata, c_hit,
      output busy, owner
   );

   modport master (
      output a_req, a_rw, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_rw, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  c_enab, c_rw, c_addr, c_wdata,
      output c_rdata, c_hit,
      input  busy, owner
   );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache between a fetch (A) and a data (B)
// requester. IDLE -> BUSY -> DONE; hit sampled at HIT_CYC, miss ends at MISS_CYC.
//
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low reset
//   bus  cache_arbiter_if.slave (requesters, cache, busy/owner status)
//   hit_cnt/miss_cnt  16-bit saturating counters, only with CACHE_ARB_STATS_EN
module cache_arbiter #(
   parameter int d_width  = 8,
   parameter int a_width  = 8,
   parameter int HIT_CYC  = 2,
   parameter int MISS_CYC = 15
) (
   input logic            clk,
   input logic            clr,
   cache_arbiter_if.slave bus
`ifdef CACHE_ARB_STATS_EN
   ,
   output logic [15:0]    hit_cnt,
   output logic [15:0]    miss_cnt
`endif
);

   localparam int CW = $clog2(MISS_CYC + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic               c_enab, c_enab_nxt;
   logic               c_rw, c_rw_nxt;
   logic [a_width-1:0] c_addr, c_addr_nxt;
   logic [d_width-1:0] c_wdata, c_wdata_nxt;
   logic               a_ack, a_ack_nxt;
   logic               b_ack, b_ack_nxt;
   logic [d_width-1:0] a_rdata, a_rdata_nxt;
   logic [d_width-1:0] b_rdata, b_rdata_nxt;
   logic               busy, busy_nxt;
   logic               owner, owner_nxt;
   // prio: 1 = B wins a tie, 0 = A wins a tie
   logic               prio, prio_nxt;

   logic               grant_b;
   logic               hit_evt;
   logic               miss_evt;

`ifdef CACHE_ARB_STATS_EN
   logic [15:0] hit_q, hit_nxt;
   logic [15:0] miss_q, miss_nxt;
`endif

   // A tie goes to whoever was not granted last.
   assign grant_b = bus.b_req & (~bus.a_req | prio);

   // MISS_CYC > HIT_CYC, so both events can never fire together.
   assign hit_evt  = (state == BUSY) && (cnt == CW'(HIT_CYC)) && bus.c_hit;
   assign miss_evt = (state == BUSY) && (cnt == CW'(MISS_CYC)) && !hit_evt;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      c_enab_nxt  = c_enab;
      c_rw_nxt    = c_rw;
      c_addr_nxt  = c_addr;
      c_wdata_nxt = c_wdata;
      a_ack_nxt   = a_ack;
      b_ack_nxt   = b_ack;
      a_rdata_nxt = a_rdata;
      b_rdata_nxt = b_rdata;
      busy_nxt    = busy;
      owner_nxt   = owner;
      prio_nxt    = prio;
      unique case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               state_nxt   = BUSY;
               cnt_nxt     = '0;
               c_enab_nxt  = 1'b1;
               busy_nxt    = 1'b1;
               owner_nxt   = grant_b;
               prio_nxt    = ~grant_b;
               c_rw_nxt    = grant_b ? bus.b_rw    : bus.a_rw;
               c_addr_nxt  = grant_b ? bus.b_addr  : bus.a_addr;
               c_wdata_nxt = grant_b ? bus.b_wdata : bus.a_wdata;
            end
         end
         BUSY: begin
            if (hit_evt || miss_evt) begin
               state_nxt  = DONE;
               c_enab_nxt = 1'b0;
               if (owner) begin
                  b_ack_nxt = 1'b1;
                  if (!c_rw) b_rdata_nxt = bus.c_rdata;
               end else begin
                  a_ack_nxt = 1'b1;
                  if (!c_rw) a_rdata_nxt = bus.c_rdata;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            a_ack_nxt = 1'b0;
            b_ack_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         cnt     <= '0;
         c_enab  <= 1'b0;
         c_rw    <= 1'b0;
         c_addr  <= '0;
         c_wdata <= '0;
         a_ack   <= 1'b0;
         b_ack   <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
         busy    <= 1'b0;
         owner   <= 1'b0;
         prio    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         c_enab  <= c_enab_nxt;
         c_rw    <= c_rw_nxt;
         c_addr  <= c_addr_nxt;
         c_wdata <= c_wdata_nxt;
         a_ack   <= a_ack_nxt;
         b_ack   <= b_ack_nxt;
         a_rdata <= a_rdata_nxt;
         b_rdata <= b_rdata_nxt;
         busy    <= busy_nxt;
         owner   <= owner_nxt;
         prio    <= prio_nxt;
      end
   end

`ifdef CACHE_ARB_STATS_EN
   always_comb begin
      hit_nxt  = hit_q;
      miss_nxt = miss_q;
      if (hit_evt && hit_q != 16'hFFFF)   hit_nxt  = hit_q + 16'd1;
      if (miss_evt && miss_q != 16'hFFFF) miss_nxt = miss_q + 16'd1;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         hit_q  <= hit_nxt;
         miss_q <= miss_nxt;
      end
   end

   assign hit_cnt  = hit_q;
   assign miss_cnt = miss_q;
`endif

   assign bus.c_enab  = c_enab;
   assign bus.c_rw    = c_rw;
   assign bus.c_addr  = c_addr;
   assign bus.c_wdata = c_wdata;
   assign bus.a_ack   = a_ack;
   assign bus.b_ack   = b_ack;
   assign bus.a_rdata = a_rdata;
   assign bus.b_rdata = b_rdata;
   assign bus.busy    = busy;
   assign bus.owner   = owner;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter: vector table of single
// transactions plus round-robin, mid-miss reset and dropped-request sequences.
module tb_cache_arbiter;

   logic clk = 1'b0;
   logic clr = 1'b0;

   cache_arbiter_if #(.d_width(8), .a_width(8)) bus ();

`ifdef CACHE_ARB_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   cache_arbiter #(
      .d_width(8),
      .a_width(8),
      .HIT_CYC(2),
      .MISS_CYC(15)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
`ifdef CACHE_ARB_STATS_EN
      ,
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       b;
      logic       rw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] crd;
      logic       hit;
      int         lat;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } vec_t;

   vec_t tbl[6];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs();
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   task automatic run(input vec_t v, input int drop_at);
      int   n;
      int   en;
      logic got;
      logic addr_ok;
      if (v.b) begin
         bus.b_req = 1'b1; bus.b_rw = v.rw;
         bus.b_addr = v.addr; bus.b_wdata = v.wdata;
      end else begin
         bus.a_req = 1'b1; bus.a_rw = v.rw;
         bus.a_addr = v.addr; bus.a_wdata = v.wdata;
      end
      bus.c_hit   = v.hit;
      bus.c_rdata = v.crd;
      tick();
      chk("grant_busy", 32'(bus.busy), 32'd1);
      chk("grant_owner", 32'(bus.owner), 32'(v.b));
      chk("grant_enab", 32'(bus.c_enab), 32'd1);
      chk("grant_addr", 32'(bus.c_addr), 32'(v.addr));
      chk("grant_rw", 32'(bus.c_rw), 32'(v.rw));
      chk("grant_wdata", 32'(bus.c_wdata), 32'(v.wdata));
      en = 1; n = 0; got = 1'b0; addr_ok = 1'b1;
      while (!got && n < 40) begin
         tick();
         n++;
         if (n == drop_at) drop_reqs();
         if (bus.a_ack || bus.b_ack) begin
            got = 1'b1;
         end else begin
            if (bus.c_enab) en++;
            if (bus.c_addr !== v.addr || bus.c_rw !== v.rw) addr_ok = 1'b0;
         end
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL ack_timeout: got no ack want ack within 40");
      end
      chk("latency", 32'(n), 32'(v.lat));
      chk("enab_cycles", 32'(en), 32'(v.lat));
      chk("addr_stable", 32'(addr_ok), 32'd1);
      chk("own_ack", 32'(v.b ? bus.b_ack : bus.a_ack), 32'd1);
      chk("other_ack", 32'(v.b ? bus.a_ack : bus.b_ack), 32'd0);
      chk("done_enab", 32'(bus.c_enab), 32'd0);
      chk("a_rdata", 32'(bus.a_rdata), 32'(v.exp_a));
      chk("b_rdata", 32'(bus.b_rdata), 32'(v.exp_b));
      drop_reqs();
      tick();
      chk("ack_width", 32'(bus.a_ack | bus.b_ack), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_enab"}, 32'(bus.c_enab), 32'd0);
      chk({nm, "_rw"}, 32'(bus.c_rw), 32'd0);
      chk({nm, "_addr"}, 32'(bus.c_addr), 32'd0);
      chk({nm, "_wdata"}, 32'(bus.c_wdata), 32'd0);
      chk({nm, "_acks"}, 32'({bus.a_ack, bus.b_ack}), 32'd0);
      chk({nm, "_a_rdata"}, 32'(bus.a_rdata), 32'd0);
      chk({nm, "_b_rdata"}, 32'(bus.b_rdata), 32'd0);
      chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
      chk({nm, "_owner"}, 32'(bus.owner), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   n;
      int   hits;
      int   misses;
      logic got;

      tbl[0] = '{b:1'b0, rw:1'b0, addr:8'h05, wdata:8'h00, crd:8'hA5,
                 hit:1'b1, lat:3, exp_a:8'hA5, exp_b:8'h00};
      tbl[1] = '{b:1'b1, rw:1'b1, addr:8'h09, wdata:8'h3C, crd:8'h77,
                 hit:1'b0, lat:16, exp_a:8'hA5, exp_b:8'h00};
      tbl[2] = '{b:1'b1, rw:1'b0, addr:8'h10, wdata:8'h00, crd:8'h5A,
                 hit:1'b1, lat:3, exp_a:8'hA5, exp_b:8'h5A};
      tbl[3] = '{b:1'b0, rw:1'b1, addr:8'h20, wdata:8'h11, crd:8'hEE,
                 hit:1'b1, lat:3, exp_a:8'hA5, exp_b:8'h5A};
      tbl[4] = '{b:1'b0, rw:1'b0, addr:8'h30, wdata:8'h00, crd:8'hC3,
                 hit:1'b0, lat:16, exp_a:8'hC3, exp_b:8'h5A};
      tbl[5] = '{b:1'b1, rw:1'b0, addr:8'h40, wdata:8'h00, crd:8'h99,
                 hit:1'b1, lat:3, exp_a:8'hC3, exp_b:8'h99};

      bus.a_req = 1'b0; bus.a_rw = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_rw = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
      bus.c_rdata = '0; bus.c_hit = 1'b0;

      #12;
      chk_zero("reset");
      @(negedge clk) clr = 1'b1;
      tick();

      hits = 0;
      misses = 0;
      for (int i = 0; i < 6; i++) begin
         run(tbl[i], -1);
         if (tbl[i].hit) hits++;
         else misses++;
      end

`ifdef CACHE_ARB_STATS_EN
      chk("hit_cnt", 32'(hit_cnt), 32'(hits));
      chk("miss_cnt", 32'(miss_cnt), 32'(misses));
`endif

      // Fresh reset, then both requesters hold req: A,B,A,B.
      clr = 1'b0;
      #2;
`ifdef CACHE_ARB_STATS_EN
      chk("clr_hit_cnt", 32'(hit_cnt), 32'd0);
      chk("clr_miss_cnt", 32'(miss_cnt), 32'd0);
`endif
      @(negedge clk) clr = 1'b1;
      bus.c_hit = 1'b1; bus.c_rdata = 8'h11;
      bus.a_req = 1'b1; bus.a_rw = 1'b0; bus.a_addr = 8'h01;
      bus.b_req = 1'b1; bus.b_rw = 1'b0; bus.b_addr = 8'h02;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_grant", 32'(bus.busy), 32'd1);
         chk("rr_owner", 32'(bus.owner), 32'(k % 2));
         chk("rr_addr", 32'(bus.c_addr), (k % 2) ? 32'h02 : 32'h01);
         n = 0; got = 1'b0;
         while (!got && n < 40) begin
            tick();
            n++;
            if (bus.a_ack || bus.b_ack) got = 1'b1;
         end
         chk("rr_lat", 32'(n), 32'd3);
         chk("rr_ack", 32'({bus.a_ack, bus.b_ack}),
             (k % 2) ? 32'b01 : 32'b10);
         tick();
         chk("rr_idle", 32'(bus.busy), 32'd0);
      end
      drop_reqs();

      // Reset at cnt=7 of a miss: everything clears at once.
      bus.a_req = 1'b1; bus.a_rw = 1'b0; bus.a_addr = 8'h55;
      bus.c_hit = 1'b0; bus.c_rdata = 8'h66;
      tick();
      chk("mid_grant", 32'(bus.busy), 32'd1);
      for (int j = 0; j < 7; j++) tick();
      clr = 1'b0;
      #1;
      chk_zero("midrst");
      bus.a_req = 1'b0;
      @(negedge clk) clr = 1'b1;
      tick();
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_ack", 32'(bus.a_ack | bus.b_ack), 32'd0);
      v = '{b:1'b0, rw:1'b0, addr:8'h07, wdata:8'h00, crd:8'h5C,
            hit:1'b1, lat:3, exp_a:8'h5C, exp_b:8'h00};
      run(v, -1);

      // A drops req at cnt=1: still completes with a single ack.
      v = '{b:1'b0, rw:1'b0, addr:8'h0A, wdata:8'h00, crd:8'h3E,
            hit:1'b1, lat:3, exp_a:8'h3E, exp_b:8'h00};
      run(v, 1);
      tick();
      chk("drop_no_regrant", 32'(bus.busy), 32'd0);
      chk("drop_single_ack", 32'(bus.a_ack), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
